true_sync_fifo: RTL and testbench

//   Single-clock first-in/first-out buffer with a registered read port, built on a

---
 rtl/true_sync_fifo_if.sv | 30 +++
 rtl/true_sync_fifo.sv | 74 +++++++
 tb/tb_true_sync_fifo.sv | 138 +++++++++++++
 3 files changed

// File: rtl/true_sync_fifo_if.sv
// Push/pop handshake and status bundle for true_sync_fifo.
// The master drives requests and write data; the slave returns read data and flags.
interface true_sync_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  push;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    modport master (
        output push,
        output wr_data,
        output pop,
        input  rd_data,
        input  fifo_full,
        input  fifo_empty
    );

    modport slave (
        input  push,
        input  wr_data,
        input  pop,
        output rd_data,
        output fifo_full,
        output fifo_empty
    );
endinterface

// File: rtl/true_sync_fifo.sv
// Single-clock FIFO on a register-array RAM with a registered read port.
// The full/empty flags are registered from the next count, so they move one edge after acceptance.
module true_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    true_sync_fifo_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("true_sync_fifo: FIFO_DEPTH must be a power of two and >= 2");
    end

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    // Acceptance uses the flags as they stand before the edge.
    assign w_push_ok = bus.push && !r_full;
    assign w_pop_ok  = bus.pop  && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_rd_data <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            r_empty <= (w_count_nxt == CNT_W'(0));
        end
    end

    // Storage is deliberately not reset; only written slots are ever read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.fifo_full  = r_full;
    assign bus.fifo_empty = r_empty;
endmodule

// File: tb/tb_true_sync_fifo.sv
// Scoreboard bench for true_sync_fifo: the stimulus queues expected post-edge outputs,
// and a negedge monitor pops each entry and compares it with the DUT.
module tb_true_sync_fifo;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [DW-1:0] rd;
        logic          full;
        logic          empty;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    exp_t          sb[$];
    logic [DW-1:0] mdl[$];
    logic [DW-1:0] last_rd;

    true_sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

    true_sync_fifo #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the oldest queued expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rd_data",    bus.rd_data,                 e.rd);
            check("fifo_full",  DW'(bus.fifo_full),  DW'(e.full));
            check("fifo_empty", DW'(bus.fifo_empty), DW'(e.empty));
        end
    end

    // One cycle of stimulus; the expected outcome is derived from a queue of stored words.
    task automatic step(input bit rst_lo, input bit p, input bit q, input logic [DW-1:0] d);
        exp_t e;
        bit   can_push;
        bit   can_pop;
        @(negedge clk);
        #1;
        reset       = !rst_lo;
        bus.push    = p;
        bus.pop     = q;
        bus.wr_data = d;
        if (rst_lo) begin
            mdl.delete();
            last_rd = '0;
        end else begin
            can_push = p && (mdl.size() < DEPTH);
            can_pop  = q && (mdl.size() > 0);
            if (can_pop)  last_rd = mdl.pop_front();
            if (can_push) mdl.push_back(d);
        end
        e.rd    = last_rd;
        e.full  = (mdl.size() == DEPTH);
        e.empty = (mdl.size() == 0);
        sb.push_back(e);
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        last_rd     = '0;
        reset       = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.wr_data = '0;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // Single words through
        step(0, 1, 0, 32'hAA);
        step(0, 0, 1, 0);
        step(0, 1, 0, 32'hBB);
        step(0, 0, 1, 0);
        step(0, 1, 0, 32'hCC);
        step(0, 0, 1, 0);

        // Fill, overflow, push+pop at full, then drain
        for (int i = 0; i < 16; i++) step(0, 1, 0, DW'(i));
        step(0, 1, 0, 32'hDEAD);
        step(0, 1, 1, 32'hBEEF);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0);

        // Pop while empty holds rd_data (0x0F), then push+pop while empty
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 32'h77);
        step(0, 0, 1, 0);

        // Steady state with 8 stored across pointer wrap
        for (int i = 0; i < 8; i++)  step(0, 1, 0, 32'h100 + DW'(i));
        for (int i = 8; i < 28; i++) step(0, 1, 1, 32'h100 + DW'(i));
        for (int i = 0; i < 9; i++)  step(0, 0, 1, 0);

        // Reset mid-stream with push/pop held during reset
        for (int i = 0; i < 5; i++) step(0, 1, 0, 32'h200 + DW'(i));
        step(1, 1, 1, 32'h999);
        step(1, 1, 1, 32'h998);
        step(0, 0, 0, 0);
        step(0, 1, 0, 32'h55);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
